// File: rtl/step_monitor_pkg.sv
// Shared encodings and widths for the run/step debug-view controller.
package step_monitor_pkg;

    localparam int unsigned BTN_W   = 4;
    localparam int unsigned PC_W    = 9;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned DIGIT_W = 16;
    localparam int unsigned REG_W   = 5;

    localparam int unsigned BTN_STEP = 0;
    localparam int unsigned BTN_RUN  = 1;
    localparam int unsigned BTN_VIEW = 2;
    localparam int unsigned BTN_REG  = 3;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_STEP = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        VIEW_PC    = 3'd0,
        VIEW_INSTR = 3'd1,
        VIEW_REG   = 3'd2,
        VIEW_ALU   = 3'd3,
        VIEW_CNT   = 3'd4
    } view_t;

    localparam view_t VIEW_LAST = VIEW_CNT;

    // Advance the display view, wrapping after the last one.
    function automatic view_t next_view(input view_t v);
        if (v == VIEW_LAST) return VIEW_PC;
        return view_t'(3'(v + 3'd1));
    endfunction

    function automatic logic [DIGIT_W-1:0] pick_half(input logic [WORD_W-1:0] word,
                                                    input logic hi);
        return hi ? word[WORD_W-1:DIGIT_W] : word[DIGIT_W-1:0];
    endfunction

endpackage

// File: rtl/step_monitor_if.sv
// Board-side signal bundle between the CPU/display and the step monitor.
interface step_monitor_if;
    import step_monitor_pkg::*;

    logic [BTN_W-1:0]   button;
    logic               hi_half;
    logic [PC_W-1:0]    pc;
    logic [WORD_W-1:0]  instr;
    logic [WORD_W-1:0]  reg_rdat;
    logic [WORD_W-1:0]  alu_result;
    logic               cpu_clk_en;
    logic [REG_W-1:0]   reg_sel;
    logic [DIGIT_W-1:0] digit_node;
    logic [3:0]         bin;
    logic               running;

    modport master (
        output button, hi_half, pc, instr, reg_rdat, alu_result,
        input  cpu_clk_en, reg_sel, digit_node, bin, running
    );

    modport slave (
        input  button, hi_half, pc, instr, reg_rdat, alu_result,
        output cpu_clk_en, reg_sel, digit_node, bin, running
    );
endinterface

// File: rtl/step_monitor_btn_edge.sv
// Synchronises slow-domain button levels and flags one-cycle rising edges.
module btn_edge #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise_c
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
            prev <= '0;
        end else begin
            sync_q[0] <= level;
            for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
            prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_c = sync_q[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/step_monitor.sv
// Run/step clock-enable generator and debug display selector for the CPU board.
module step_monitor
    import step_monitor_pkg::*;
#(
    parameter int unsigned RUN_DIV     = 25000000,
    parameter int unsigned DIV_W       = 25,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    step_monitor_if.slave  bus
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    logic [BTN_W-1:0]   edge_c;
    state_t             state;
    logic [DIV_W-1:0]   divider;
    logic               cpu_clk_en;
    logic               running;
    logic [DIGIT_W-1:0] step_cnt;
    view_t              view;
    logic [REG_W-1:0]   reg_idx;
    logic [DIGIT_W-1:0] digit_node;
    logic [3:0]         bin;

    btn_edge #(
        .WIDTH       (BTN_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_btn_edge (
        .clk    (clk),
        .rst    (rst),
        .level  (bus.button),
        .rise_c (edge_c)
    );

    // Run/step FSM; the enable pulse is registered with the state it belongs to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_STOP;
            divider    <= '0;
            cpu_clk_en <= 1'b0;
            running    <= 1'b0;
        end else begin
            cpu_clk_en <= 1'b0;
            unique case (state)
                ST_STOP: begin
                    if (edge_c[BTN_RUN]) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                        divider <= '0;
                    end else if (edge_c[BTN_STEP]) begin
                        state      <= ST_STEP;
                        cpu_clk_en <= 1'b1;
                    end
                end
                ST_STEP: state <= ST_STOP;
                ST_RUN: begin
                    if (edge_c[BTN_RUN]) begin
                        state   <= ST_STOP;
                        running <= 1'b0;
                        divider <= '0;
                    end else if (divider == DIV_LAST) begin
                        divider    <= '0;
                        cpu_clk_en <= 1'b1;
                    end else begin
                        divider <= divider + DIV_W'(1);
                    end
                end
                default: begin
                    state   <= ST_STOP;
                    running <= 1'b0;
                    divider <= '0;
                end
            endcase
        end
    end

    // Step counter plus view and register-index selection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_cnt <= '0;
            view     <= VIEW_PC;
            reg_idx  <= '0;
        end else begin
            if (cpu_clk_en) step_cnt <= step_cnt + DIGIT_W'(1);
            if (edge_c[BTN_VIEW]) view <= next_view(view);
            if (edge_c[BTN_REG] && view == VIEW_REG) reg_idx <= reg_idx + REG_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit_node <= '0;
            bin        <= '0;
        end else begin
            unique case (view)
                VIEW_PC:    digit_node <= {7'b0, bus.pc};
                VIEW_INSTR: digit_node <= pick_half(bus.instr, bus.hi_half);
                VIEW_REG:   digit_node <= pick_half(bus.reg_rdat, bus.hi_half);
                VIEW_ALU:   digit_node <= pick_half(bus.alu_result, bus.hi_half);
                VIEW_CNT:   digit_node <= step_cnt;
                default:    digit_node <= '0;
            endcase
            bin <= {running, 3'(view)};
        end
    end

    assign bus.cpu_clk_en = cpu_clk_en;
    assign bus.running    = running;
    assign bus.reg_sel    = reg_idx;
    assign bus.digit_node = digit_node;
    assign bus.bin        = bin;

endmodule

// File: tb/tb_step_monitor.sv
// Directed bench for step_monitor with a short run divider.
module tb_step_monitor;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   pulses;
    int   long_pulses;
    logic prev_en;

    step_monitor_if bus();

    step_monitor #(
        .RUN_DIV     (4),
        .DIV_W       (25),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && bus.cpu_clk_en === 1'b1) pulses++;
        if (rst && bus.cpu_clk_en === 1'b1 && prev_en) long_pulses++;
        prev_en = (bus.cpu_clk_en === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic press(input int b, input int hold, input int gap);
        bus.button[b] = 1'b1;
        tick(hold);
        bus.button[b] = 1'b0;
        tick(gap);
    endtask

    task automatic wait_running(input logic val, input string tag);
        int n;
        n = 0;
        while (bus.running !== val && n < 20) begin
            tick(1);
            n++;
        end
        check(tag, 32'(bus.running), 32'(val));
    endtask

    initial begin
        int snap;
        int n;
        checks      = 0;
        errors      = 0;
        pulses      = 0;
        long_pulses = 0;
        prev_en     = 1'b0;
        rst            = 1'b0;
        bus.button     = '0;
        bus.hi_half    = 1'b0;
        bus.pc         = 9'h1A5;
        bus.instr      = 32'h1234_5678;
        bus.reg_rdat   = 32'hDEAD_BEEF;
        bus.alu_result = 32'hCAFE_F00D;

        #2;
        check("rst_en",      32'(bus.cpu_clk_en), 32'd0);
        check("rst_digit",   32'(bus.digit_node), 32'h0);
        check("rst_bin",     32'(bus.bin),        32'h0);
        check("rst_running", 32'(bus.running),    32'd0);
        check("rst_reg_sel", 32'(bus.reg_sel),    32'd0);

        tick(2);
        rst = 1'b1;
        tick(50);
        check("idle_pulses", 32'(pulses),         32'd0);
        check("idle_digit",  32'(bus.digit_node), 32'h01A5);
        check("idle_bin",    32'(bus.bin),        32'h0);

        // Three single steps.
        for (int i = 0; i < 3; i++) press(0, 10, 10);
        check("step_pulses", 32'(pulses), 32'd3);

        // View to REG, then index wrap.
        press(2, 3, 5);
        press(2, 3, 5);
        check("view_reg_bin", 32'(bus.bin), 32'h2);
        for (int i = 0; i < 33; i++) press(3, 3, 3);
        check("reg_wrap", 32'(bus.reg_sel), 32'd1);

        bus.hi_half = 1'b1;
        tick(2);
        check("reg_hi", 32'(bus.digit_node), 32'hDEAD);
        bus.hi_half = 1'b0;
        #1;
        check("reg_lo_latency", 32'(bus.digit_node), 32'hDEAD);
        tick(1);
        check("reg_lo", 32'(bus.digit_node), 32'hBEEF);

        press(2, 3, 5);
        check("alu_lo",  32'(bus.digit_node), 32'hF00D);
        press(2, 3, 5);
        check("cnt_val", 32'(bus.digit_node), 32'h0003);
        check("cnt_bin", 32'(bus.bin),        32'h4);
        press(2, 3, 5);
        check("pc_wrap_bin",   32'(bus.bin),        32'h0);
        check("pc_wrap_digit", 32'(bus.digit_node), 32'h01A5);
        press(3, 3, 5);
        check("reg_hold", 32'(bus.reg_sel), 32'd1);

        // Free run with divide-by-4.
        bus.button[1] = 1'b1;
        wait_running(1'b1, "run_enter");
        bus.button[1] = 1'b0;
        snap = pulses;
        tick(16);
        check("run_pulses", 32'(pulses - snap), 32'd4);
        check("run_bin", 32'(bus.bin), 32'h8);

        snap = pulses;
        press(0, 4, 12);
        check("run_step_ignored", 32'(pulses - snap), 32'd4);

        bus.button[1] = 1'b1;
        wait_running(1'b0, "run_exit");
        bus.button[1] = 1'b0;
        snap = pulses;
        tick(20);
        check("stop_pulses", 32'(pulses - snap), 32'd0);

        // Run beats step when both rise together.
        snap = pulses;
        bus.button[0] = 1'b1;
        bus.button[1] = 1'b1;
        wait_running(1'b1, "prio_run");
        check("prio_no_step", 32'(pulses - snap), 32'd0);
        bus.button = '0;

        // Async reset while the enable is high.
        n = 0;
        while (bus.cpu_clk_en !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        check("en_seen", 32'(bus.cpu_clk_en), 32'd1);
        rst = 1'b0;
        #1;
        check("async_en",      32'(bus.cpu_clk_en), 32'd0);
        check("async_running", 32'(bus.running),    32'd0);
        check("async_digit",   32'(bus.digit_node), 32'h0);
        check("async_bin",     32'(bus.bin),        32'h0);
        check("async_reg_sel", 32'(bus.reg_sel),    32'd0);
        tick(1);
        rst = 1'b1;
        snap = pulses;
        tick(20);
        check("post_rst_pulses",  32'(pulses - snap),   32'd0);
        check("post_rst_running", 32'(bus.running),     32'd0);
        check("post_rst_digit",   32'(bus.digit_node),  32'h01A5);
        check("post_rst_bin",     32'(bus.bin),         32'h0);
        check("pulse_width",      32'(long_pulses),     32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/step_monitor.md
Name: step_monitor

Overview:
- Run/step and debug-view controller for the single-cycle CPU board build.
- Downstream of the button debouncer; upstream of the CPU clock enable, register-file debug read port (ReadC) and the 4-digit seven-segment display driver.
- Turns debounced buttons into single-step or free-run CPU clock-enable pulses.
- Selects which CPU value (PC, instruction, register, ALU result, step count) drives the display as 16 hex bits plus decimal points.

Parameters:
- RUN_DIV, 25000000: clk cycles between enable pulses in RUN state; legal range 2..2^DIV_W-1.
- DIV_W, 25: width of the run divider counter.
- SYNC_STAGES, 2: synchroniser depth for button inputs, which come from the slow debounce clock domain.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- button  in  4  debounced levels: [0] step, [1] run/stop toggle, [2] view select, [3] register index increment.
- hi_half  in  1  switch; 1 shows bits [31:16] of 32-bit views, 0 shows bits [15:0].
- pc  in  9  current PC.
- instr  in  32  current instruction word.
- reg_rdat  in  32  register-file read data for reg_sel.
- alu_result  in  32  ALU result.
- cpu_clk_en  out  1  one-clk-wide CPU advance pulse.
- reg_sel  out  5  register index to the register-file debug read port.
- digit_node  out  16  hex nibbles to the display.
- bin  out  4  decimal-point enables to the display.
- running  out  1  high in RUN state.

Behaviour:
- Reset (rst low, async): state=STOP; view=PC; reg_sel=0; step_cnt=0; divider=0; cpu_clk_en=0; digit_node=0; bin=0; running=0; synchroniser and edge flops=0.
- Inputs: each button bit passes through SYNC_STAGES flops. An edge is sync & ~prev, exactly one clk per press. Holding a button gives no repeat.
- States: STOP, STEP, RUN (encoded in package).
  - STOP + run edge -> RUN; divider cleared. Run edge has priority: a simultaneous step edge is dropped.
  - STOP + step edge -> STEP.
  - STEP -> STOP unconditionally next cycle. cpu_clk_en=1 during the single STEP cycle. Edges arriving in STEP are ignored.
  - RUN: divider increments each clk. At RUN_DIV-1 it wraps to 0 and cpu_clk_en pulses for 1 clk. Step edges are ignored.
  - RUN + run edge -> STOP; divider cleared; no pulse that cycle, even if the divider was at terminal count.
- cpu_clk_en is registered, i.e. Moore output of the state/divider.
- step_cnt: 16-bit, increments on every cycle with cpu_clk_en=1; wraps 0xFFFF->0.
- View select: cycles PC->INSTR->REG->ALU->CNT->PC on each button[2] edge; wraps after CNT.
- reg_sel: increments on a button[3] edge only when view=REG; wraps 31->0; otherwise holds.
- Display value selection (registered, 1 clk latency from inputs):
  - PC view: {7'b0,pc}; hi_half ignored.
  - INSTR / REG / ALU views: hi_half ? [31:16] : [15:0] of instr / reg_rdat / alu_result.
  - CNT view: step_cnt; hi_half ignored.
- bin={running, view[2:0]} with view encoded PC=0, INSTR=1, REG=2, ALU=3, CNT=4; registered alongside digit_node.
- running is asserted in RUN state only; registered.
- Reset asserted mid-pulse forces cpu_clk_en low immediately (async).

Decomposition:
- Shared package: state encodings (STOP/STEP/RUN), view encodings (VIEW_PC..VIEW_CNT), VIEW_LAST constant, button index constants (BTN_STEP=0, BTN_RUN=1, BTN_VIEW=2, BTN_REG=3).
- One sub-module: btn_edge, a parameterised-width synchroniser plus rising-edge detector, instantiated once with width 4.

Test Plan:
- Reset/idle: release rst, hold buttons 0 for 50 clk -> cpu_clk_en never 1; digit_node=pc (pc=9'h1A5 gives 16'h01A5); bin=4'b0000.
- Single step: in STOP, press button[0] for 10 clk, 3 times -> exactly 3 one-clk cpu_clk_en pulses, each 1 clk after state entry; CNT view shows 16'h0003.
- Run divide (RUN_DIV=4): press button[1] -> running=1 and cpu_clk_en pulses every 4th clk (4 pulses in 16 clk); press button[1] again -> pulses stop, running=0.
- Priority: button[0] and button[1] rise on the same clk in STOP -> RUN entered, no STEP pulse; step press during RUN -> no extra pulse.
- View/register cycling: 2 view presses -> bin[2:0]=2; 33 button[3] presses -> reg_sel=1 (wrap). Drive reg_rdat=32'hDEADBEEF: hi_half=1 gives 16'hDEAD; hi_half=0 gives 16'hBEEF, one clk after change.
- Async reset: assert rst while running with cpu_clk_en high -> all outputs 0 without a clock edge; after release, state STOP and view PC.
